// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/state enums and the illegal-opcode constant for alu_exec
package alu_pkg;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101,
    OP_SHL = 3'b110,
    OP_ILL = 3'b111
  } op_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic [2:0] ALU_ILLEGAL = 3'b111;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier, one multiplier bit per step
module alu_mul_seq #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      step,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic [2*DATA_WIDTH-1:0]   product,
  output logic                      last
);
  localparam int W = DATA_WIDTH;
  localparam int CW = $clog2(W);
  logic [2*W-1:0] acc, mcand;
  logic [W-1:0] mplier;
  logic [CW-1:0] cnt;
  // product is the accumulator after the current step, so the final step's value can be latched directly
  assign product = acc + (mplier[0] ? mcand : '0);
  assign last = cnt == CW'(W - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
    end else if (start) begin
      acc <= '0;
      mcand <= {{W{1'b0}}, a};
      mplier <= b;
      cnt <= '0;
    end else if (step) begin
      acc <= product;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/alu_exec.sv
// alu_exec: multi-cycle ALU with IDLE/RUN/DONE FSM; MUL built only with ALU_MUL_EN
module alu_exec
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     A,
  input  logic [DATA_WIDTH-1:0]     B,
  input  logic [2:0]                oper,
  input  logic                      exec,
  output logic [2*DATA_WIDTH-1:0]   result,
  output logic                      done,
  output logic                      busy,
  output logic                      carry,
  output logic                      zero,
  output logic                      err
);
  localparam int W = DATA_WIDTH;
  state_e state;
  op_e op;
  logic [W:0] sum, diff, shl;
  logic [W-1:0] lo;
  logic c, ill, is_mul;
  assign op = op_e'(oper);
  assign busy = state != IDLE;
`ifdef ALU_MUL_EN
  logic [2*W-1:0] prod;
  logic last;
  assign is_mul = op == OP_MUL;
  alu_mul_seq #(.DATA_WIDTH(W)) u_mul (
    .clk(clk),
    .rst(reset),
    .start(state == IDLE && exec && is_mul),
    .step(state == RUN),
    .a(A),
    .b(B),
    .product(prod),
    .last(last)
  );
`else
  assign is_mul = 1'b0;
`endif
  always_comb begin
    sum = {1'b0, A} + {1'b0, B};
    diff = {1'b0, A} - {1'b0, B};
    shl = {1'b0, A} << B[2:0];
    lo = op == OP_ADD ? sum[W-1:0] :
         op == OP_SUB ? diff[W-1:0] :
         op == OP_AND ? A & B :
         op == OP_OR  ? A | B :
         op == OP_XOR ? A ^ B :
         op == OP_SHL ? shl[W-1:0] : '0;
    c = (op == OP_ADD && sum[W]) || (op == OP_SUB && diff[W]) || (op == OP_SHL && shl[W]);
    ill = oper == ALU_ILLEGAL || (op == OP_MUL && !is_mul);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      result <= '0;
      done <= 1'b0;
      carry <= 1'b0;
      zero <= 1'b0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (exec && is_mul) state <= RUN;
          else if (exec) begin
            state <= DONE;
            done <= 1'b1;
            result <= {{W{1'b0}}, lo};
            carry <= c;
            zero <= lo == '0;
            err <= ill;
          end
`ifdef ALU_MUL_EN
        RUN:
          if (last) begin
            state <= DONE;
            done <= 1'b1;
            result <= prod;
            carry <= 1'b0;
            zero <= prod == '0;
            err <= 1'b0;
          end
`endif
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed self-checking bench for alu_exec (DATA_WIDTH=8)
module tb_alu_exec;
  import alu_pkg::*;
  logic clk = 0, reset = 1, exec = 0;
  logic [7:0] A = 0, B = 0;
  logic [2:0] oper = 0;
  logic [15:0] result;
  logic done, busy, carry, zero, err;
  int tests = 0, fails = 0;

  alu_exec #(.DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .oper(oper), .exec(exec),
    .result(result), .done(done), .busy(busy), .carry(carry), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  // issues one request sampled at the next edge k; returns in cycle k+1
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    wait_idle();
    A = a;
    B = b;
    oper = op;
    exec = 1;
    step();
    exec = 0;
  endtask

  task automatic op_chk(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic [15:0] res, input logic c, input logic z);
    do_op(a, b, op);
    chk({tag, "_out"}, {done, result, carry, zero, err}, {1'b1, res, c, z, 1'b0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int busy_n, done_n, done_at;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", {result, done, busy, carry, zero, err}, 0);
    reset = 0;

    op_chk("add_ff_01", 8'hFF, 8'h01, OP_ADD, 16'h0000, 1, 1);
    step();
    chk("add_after", {done, busy, result}, {1'b0, 1'b0, 16'h0000});
    op_chk("sub_5_7", 8'h05, 8'h07, OP_SUB, 16'h00FE, 1, 0);
    op_chk("shl_81_1", 8'h81, 8'h01, OP_SHL, 16'h0002, 1, 0);
    op_chk("shl_by0", 8'h5A, 8'h00, OP_SHL, 16'h005A, 0, 0);
    op_chk("shl_b9", 8'h40, 8'h09, OP_SHL, 16'h0080, 0, 0);
    op_chk("and", 8'hF0, 8'h3C, OP_AND, 16'h0030, 0, 0);
    op_chk("or", 8'hF0, 8'h0F, OP_OR, 16'h00FF, 0, 0);
    op_chk("xor", 8'hAA, 8'hFF, OP_XOR, 16'h0055, 0, 0);
    op_chk("add_7f_01", 8'h7F, 8'h01, OP_ADD, 16'h0080, 0, 0);

    do_op(8'h12, 8'h34, 3'b111);
    chk("ill_out", {done, err, result}, {1'b1, 1'b1, 16'h0000});
    op_chk("ill_then_add", 8'h02, 8'h03, OP_ADD, 16'h0005, 0, 0);

    // exec held through DONE must not restart the operation
    wait_idle();
    A = 8'h01; B = 8'h01; oper = OP_ADD; exec = 1;
    step();
    chk("hold_k1", {done, result}, {1'b1, 16'h0002});
    A = 8'h07; B = 8'h07;
    step();
    chk("hold_k2", {done, busy, result}, {1'b0, 1'b0, 16'h0002});
    exec = 0;

`ifdef ALU_MUL_EN
    do_op(8'hFF, 8'hFF, OP_MUL);
    busy_n = 0; done_n = 0; done_at = 0;
    for (int i = 1; i <= 12; i++) begin
      busy_n += int'(busy);
      if (done) begin done_n++; done_at = i; end
      if (i == 9) chk("mul_res", {result, carry, zero, err}, {16'hFE01, 3'b000});
      step();
    end
    chk("mul_busy_cycles", busy_n, 9);
    chk("mul_done_cycle", done_at, 9);
    chk("mul_done_count", done_n, 1);

    wait_idle();
    A = 8'h03; B = 8'h05; oper = OP_MUL; exec = 1;
    step();
    done_n = 0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 3) begin A = 8'hFF; B = 8'hFF; end
      if (done) begin
        done_n++;
        chk("mulhold_res", result, 16'h000F);
        exec = 0;
      end
      step();
    end
    exec = 0;
    chk("mulhold_done_count", done_n, 1);

    do_op(8'h03, 8'h05, OP_MUL);
    done_n = int'(done);
    step();
    done_n += int'(done);
    step();
    done_n += int'(done);
    reset = 1;
    step();
    chk("mulrst_out", {result, done, busy, carry, zero, err}, 0);
    reset = 0;
    for (int i = 0; i < 12; i++) begin
      done_n += int'(done);
      step();
    end
    chk("mulrst_no_done", done_n, 0);
    op_chk("mulrst_add", 8'h02, 8'h03, OP_ADD, 16'h0005, 0, 0);
`else
    do_op(8'hFF, 8'hFF, OP_MUL);
    chk("mul_ill_out", {done, err, result}, {1'b1, 1'b1, 16'h0000});
    step();
    chk("mul_ill_after", {done, busy}, 0);
    op_chk("mul_ill_next", 8'h02, 8'h03, OP_ADD, 16'h0005, 0, 0);
`endif

    // reset wins over exec on the same edge
    wait_idle();
    A = 8'h01; B = 8'h01; oper = OP_ADD; exec = 1; reset = 1;
    step();
    chk("rst_prio", {result, done, busy, carry, zero, err}, 0);
    reset = 0;
    exec = 0;
    step();
    chk("rst_prio_idle", {done, busy}, 0);
    op_chk("post_rst_add", 8'h02, 8'h03, OP_ADD, 16'h0005, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
